ysyx_25070198_mem_arb: RTL and testbench
========================================

Name: ysyx_25070198_mem_arb

Overview:
- Two-master to one-slave SimpleBus arbiter that sits directly downstream of the core's IFU and LSU fetch/load/store ports.
- Accepts one request at a time, either an IFU instruction fetch (read-only) or an LSU load/store, and forwards it to the single memory-side port.
- Returns the response to the originating master only.
- Adds a per-transaction timeout so a hung memory cannot stall the core silently.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT_CYC, 255, max cycles in ISSUE+WAIT before forced error response (must be >=2)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- ifu_reqValid  in  1  IFU fetch request
- ifu_reqReady  out  1  IFU request accepted this cycle
- ifu_raddr  in  AW  fetch address
- ifu_respValid  out  1  fetch data valid (1-cycle pulse)
- ifu_rdata  out  DW  fetched instruction
- lsu_reqValid  in  1  LSU request
- lsu_reqReady  out  1  LSU request accepted this cycle
- lsu_addr  in  AW  load/store address
- lsu_wen  in  1  1=store, 0=load
- lsu_wdata  in  DW  store data
- lsu_wmask  in  4  byte strobes
- lsu_respValid  out  1  LSU response (load data or store ack), 1-cycle pulse
- lsu_rdata  out  DW  load data; 0 on store
- mem_reqValid  out  1  request to memory
- mem_reqReady  in  1  memory accepts request
- mem_addr  out  AW
- mem_wen  out  1
- mem_wdata  out  DW
- mem_wmask  out  4
- mem_respValid  in  1  memory response
- mem_rdata  in  DW
- bus_err  out  1  sticky; set on any timeout, cleared only by rst

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; owner=LSU; timeout counter=0.
  - All outputs 0: reqReady, respValid, rdata, mem_* and bus_err.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = LSU if lsu_reqValid, else IFU if ifu_reqValid.
  - The granted master's reqReady is combinational and high in the same cycle; the other master's reqReady is 0.
  - On handshake: latch addr/wen/wdata/wmask and owner; go to ISSUE.
  - For IFU requests, the latched wen=0 and wmask=4'hF.
- ISSUE:
  - mem_reqValid=1 with latched fields, held stable.
  - On mem_reqReady: go to WAIT.
- WAIT:
  - mem_reqValid=0.
  - On mem_respValid: register mem_rdata (forced to 0 if latched wen=1); go to RESP.
- RESP:
  - owner's respValid=1 for exactly one cycle, with the registered data on its rdata.
  - Next state IDLE.
  - rdata holds its value after the pulse until the next response.
- Minimum latency: handshake cycle N, mem_reqReady at N+1, mem_respValid at N+2, master respValid at N+3.
- Masters must hold reqValid and payload until reqReady. reqReady is never asserted outside IDLE, so only one transaction is outstanding at a time.
- mem_respValid in IDLE, ISSUE or RESP is ignored (no state change).
- Timeout:
  - Counter clears on entering ISSUE and increments every cycle in ISSUE or WAIT.
  - On reaching TIMEOUT_CYC: drop mem_reqValid, go to RESP with rdata=0, and set bus_err.
- Simultaneous IFU and LSU requests: the non-granted master stalls, with its reqReady held at 0.
- rst asserted mid-transaction aborts immediately: no response pulse, and mem_reqValid=0 asynchronously.

Optional Feature:
- Macro YSYX_25070198_ARB_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request, the master that did not own the previous transaction wins. The priority pointer resets to favour LSU.
- Undefined: fixed LSU-over-IFU priority as described above.

Decomposition:
- Shared package ysyx_25070198_bus_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner encoding (OWN_IFU=0, OWN_LSU=1)
  - default wmask constant 4'hF
- One natural sub-module: ysyx_25070198_arb_grant, the combinational/registered priority or round-robin select producing a grant one-hot and holding the RR pointer.

Test Plan:
- IFU read alone:
  - Stimulus: ifu_raddr=0x80000000; memory returns 0x00100073 after 1 cycle.
  - Required: ifu_reqReady at N; ifu_respValid at N+3 with 0x00100073; lsu_respValid stays 0.
- LSU store:
  - Stimulus: addr=0x80001000, wdata=0xDEADBEEF, wmask=4'b0011.
  - Required: mem_* fields match; lsu_respValid pulse with lsu_rdata=0.
- Simultaneous IFU+LSU requests (macro off):
  - Required: LSU is served first; IFU is accepted in the IDLE cycle after the LSU's RESP.
  - With YSYX_25070198_ARB_RR_EN: a second simultaneous request is granted to IFU.
- Memory backpressure:
  - Stimulus: mem_reqReady held low 5 cycles.
  - Required: mem_reqValid and fields stable for those 5 cycles; the response is delayed by 5.
- Timeout:
  - Stimulus: TIMEOUT_CYC=8; memory never responds.
  - Required: owner respValid 8 cycles after entering ISSUE, with rdata=0; bus_err=1 and stays set.
- Reset in WAIT:
  - Stimulus: rst asserted in WAIT, then released.
  - Required: all outputs 0 immediately; no respValid pulse; next request is handled normally.

Source files
------------

// File: rtl/ysyx_25070198_bus_pkg.sv
// Shared SimpleBus arbiter types: FSM states, transaction owner encoding and
// the byte-strobe pattern used for instruction fetches.
package ysyx_25070198_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [3:0] WMASK_FULL = 4'hF;

endpackage

// File: rtl/ysyx_25070198_arb_grant.sv
// Master select for the memory arbiter: fixed LSU priority by default, or
// round-robin on simultaneous requests when YSYX_25070198_ARB_RR_EN is defined.
module ysyx_25070198_arb_grant
  import ysyx_25070198_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       take,
  output logic [1:0] grant,
  output owner_e     owner
);

  logic lsu_win;

`ifdef YSYX_25070198_ARB_RR_EN
  // Set when the LSU should win the next tie; starts out favouring the LSU.
  logic prio_lsu;

  assign lsu_win = lsu_valid && (prio_lsu || !ifu_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_lsu <= 1'b1;
    end else if (take) begin
      prio_lsu <= !lsu_win;
    end
  end
`else
  assign lsu_win = lsu_valid;
`endif

  // Bit positions follow the owner encoding: [1] = LSU, [0] = IFU.
  assign grant = {lsu_win, ifu_valid && !lsu_win};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= OWN_LSU;
    end else if (take) begin
      owner <= lsu_win ? OWN_LSU : OWN_IFU;
    end
  end

endmodule

// File: rtl/ysyx_25070198_mem_arb.sv
// Two-master (IFU/LSU) to one-slave SimpleBus arbiter with a per-transaction
// timeout; define YSYX_25070198_ARB_RR_EN for round-robin arbitration.
module ysyx_25070198_mem_arb
  import ysyx_25070198_bus_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_reqValid,
  output logic          ifu_reqReady,
  input  logic [AW-1:0] ifu_raddr,
  output logic          ifu_respValid,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_reqValid,
  output logic          lsu_reqReady,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_wen,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [3:0]    lsu_wmask,
  output logic          lsu_respValid,
  output logic [DW-1:0] lsu_rdata,
  output logic          mem_reqValid,
  input  logic          mem_reqReady,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic          mem_respValid,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_e        state, state_n;
  owner_e        owner;
  logic [1:0]    grant;
  logic          take, busy, timeout, got_resp, to_resp;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic          wen_q;
  logic [DW-1:0] wdata_q, resp_data, ifu_rdata_q, lsu_rdata_q;
  logic [3:0]    wmask_q;
  logic          err_q;

  assign take = (state == IDLE) && (ifu_reqValid || lsu_reqValid);

  ysyx_25070198_arb_grant u_grant (
    .clk       (clk),
    .rst       (rst),
    .ifu_valid (ifu_reqValid),
    .lsu_valid (lsu_reqValid),
    .take      (take),
    .grant     (grant),
    .owner     (owner)
  );

  assign busy      = (state == ISSUE) || (state == WAIT);
  assign timeout   = busy && (cnt == CNT_LAST);
  assign got_resp  = (state == WAIT) && mem_respValid;
  assign to_resp   = got_resp || timeout;
  assign resp_data = (got_resp && !wen_q) ? mem_rdata : '0;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // NOTE: state_n gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (take) state_n = ISSUE;
      ISSUE: begin
        if (timeout) state_n = RESP;
        else if (mem_reqReady) state_n = WAIT;
      end
      WAIT:  if (to_resp) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (take) begin
      if (grant[1]) begin
        addr_q  <= lsu_addr;
        wen_q   <= lsu_wen;
        wdata_q <= lsu_wdata;
        wmask_q <= lsu_wmask;
      end else begin
        addr_q  <= ifu_raddr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= WMASK_FULL;
      end
    end
  end

  // Counter restarts on the handshake so it reads 0 in the first ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (to_resp && owner == OWN_LSU) lsu_rdata_q <= resp_data;
      if (to_resp && owner == OWN_IFU) ifu_rdata_q <= resp_data;
      if (timeout && !got_resp) err_q <= 1'b1;
    end
  end

  // Ready is masked by rst so nothing is accepted while reset is held.
  assign ifu_reqReady  = (state == IDLE) && grant[0] && !rst;
  assign lsu_reqReady  = (state == IDLE) && grant[1] && !rst;
  assign ifu_respValid = (state == RESP) && (owner == OWN_IFU);
  assign lsu_respValid = (state == RESP) && (owner == OWN_LSU);
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign mem_reqValid  = (state == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign bus_err       = err_q;

endmodule

// File: tb/tb_ysyx_25070198_mem_arb.sv
// Directed self-checking bench for ysyx_25070198_mem_arb (TIMEOUT_CYC=8).
module tb_ysyx_25070198_mem_arb;

`ifdef YSYX_25070198_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_reqValid, ifu_reqReady, ifu_respValid;
  logic [31:0] ifu_raddr, ifu_rdata;
  logic        lsu_reqValid, lsu_reqReady, lsu_wen, lsu_respValid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_reqValid, mem_reqReady, mem_wen, mem_respValid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        bus_err;

  int total = 0;
  int bad   = 0;
  bit first_lsu;

  always #5 clk = ~clk;

  ysyx_25070198_mem_arb #(.AW(32), .DW(32), .TIMEOUT_CYC(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_reqReady  (ifu_reqReady),
    .ifu_raddr     (ifu_raddr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_reqReady  (lsu_reqReady),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .mem_reqValid  (mem_reqValid),
    .mem_reqReady  (mem_reqReady),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata),
    .bus_err       (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the handshake cycle; returns in the RESP cycle of that master.
  task automatic serve(input bit is_lsu, input logic [31:0] addr,
                       input logic [31:0] mdata, input bit wen);
    tick();
    if (is_lsu) lsu_reqValid = 1'b0;
    else        ifu_reqValid = 1'b0;
    #1;
    check("srv_issue_valid", mem_reqValid, 1);
    check("srv_issue_addr", mem_addr, addr);
    check("srv_issue_no_ready", {ifu_reqReady, lsu_reqReady}, 0);
    mem_reqReady = 1'b1;
    tick();
    mem_reqReady  = 1'b0;
    mem_respValid = 1'b1;
    mem_rdata     = mdata;
    #1;
    check("srv_wait_valid", mem_reqValid, 0);
    tick();
    mem_respValid = 1'b0;
    #1;
    check("srv_resp_valid", is_lsu ? lsu_respValid : ifu_respValid, 1);
    check("srv_other_quiet", is_lsu ? ifu_respValid : lsu_respValid, 0);
    check("srv_rdata", is_lsu ? lsu_rdata : ifu_rdata, wen ? 32'h0 : mdata);
  endtask

  initial begin
    rst = 1'b1;
    ifu_reqValid = 1'b1; ifu_raddr = 32'h0;
    lsu_reqValid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_reqReady = 1'b0; mem_respValid = 1'b0; mem_rdata = 32'h0;

    // Reset state, with an IFU request pending that must not be accepted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ifu_ready", ifu_reqReady, 0);
    check("rst_lsu_ready", lsu_reqReady, 0);
    check("rst_mem_valid", mem_reqValid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_resp", {ifu_respValid, lsu_respValid}, 0);
    check("rst_rdata", ifu_rdata | lsu_rdata, 0);
    check("rst_bus_err", bus_err, 0);
    ifu_reqValid = 1'b0;
    rst = 1'b0;

    // IFU read alone, minimum latency.
    tick();
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0000;
    #1;
    check("ifu_ready", ifu_reqReady, 1);
    check("ifu_lsu_ready", lsu_reqReady, 0);
    tick();
    ifu_reqValid = 1'b0;
    #1;
    check("ifu_mem_valid", mem_reqValid, 1);
    check("ifu_mem_addr", mem_addr, 32'h8000_0000);
    check("ifu_mem_wen", mem_wen, 0);
    check("ifu_mem_wmask", mem_wmask, 4'hF);
    mem_reqReady = 1'b1;
    tick();
    mem_reqReady = 1'b0; mem_respValid = 1'b1; mem_rdata = 32'h0010_0073;
    #1;
    check("ifu_no_early_resp", ifu_respValid, 0);
    tick();
    mem_respValid = 1'b0;
    #1;
    check("ifu_resp_valid", ifu_respValid, 1);
    check("ifu_resp_data", ifu_rdata, 32'h0010_0073);
    check("ifu_lsu_quiet", lsu_respValid, 0);
    tick();
    #1;
    check("ifu_pulse_end", ifu_respValid, 0);
    check("ifu_data_hold", ifu_rdata, 32'h0010_0073);

    // Simultaneous requests: LSU wins in both builds here (last owner was IFU).
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0004;
    lsu_reqValid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_wmask = 4'hF;
    #1;
    check("sim1_lsu_ready", lsu_reqReady, 1);
    check("sim1_ifu_stall", ifu_reqReady, 0);
    serve(1'b1, 32'h8000_2000, 32'hCAFE_F00D, 1'b0);
    check("sim1_ifu_stall_resp", ifu_reqReady, 0);
    tick();
    #1;
    check("sim1_ifu_after_resp", ifu_reqReady, 1);
    serve(1'b0, 32'h8000_0004, 32'h0000_0013, 1'b0);
    check("sim1_lsu_data_hold", lsu_rdata, 32'hCAFE_F00D);

    // LSU store: load data from memory must be replaced by 0.
    tick();
    lsu_reqValid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    #1;
    check("st_ready", lsu_reqReady, 1);
    tick();
    lsu_reqValid = 1'b0;
    #1;
    check("st_mem_valid", mem_reqValid, 1);
    check("st_mem_addr", mem_addr, 32'h8000_1000);
    check("st_mem_wen", mem_wen, 1);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_mem_wmask", mem_wmask, 4'b0011);
    mem_reqReady = 1'b1;
    tick();
    mem_reqReady = 1'b0; mem_respValid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    tick();
    mem_respValid = 1'b0; lsu_wen = 1'b0;
    #1;
    check("st_resp_valid", lsu_respValid, 1);
    check("st_resp_zero", lsu_rdata, 0);
    check("st_ifu_quiet", ifu_respValid, 0);

    // Second tie, last owner LSU: fixed priority keeps LSU, round-robin picks IFU.
    tick();
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0008;
    lsu_reqValid = 1'b1; lsu_addr = 32'h8000_2004; lsu_wen = 1'b0; lsu_wmask = 4'hF;
    #1;
    first_lsu = !RR_EN;
    check("sim2_lsu_ready", lsu_reqReady, first_lsu);
    check("sim2_ifu_ready", ifu_reqReady, !first_lsu);
    serve(first_lsu, first_lsu ? 32'h8000_2004 : 32'h8000_0008,
          first_lsu ? 32'h1111_2222 : 32'h0000_0113, 1'b0);
    tick();
    #1;
    check("sim2_loser_ready", first_lsu ? ifu_reqReady : lsu_reqReady, 1);
    serve(!first_lsu, first_lsu ? 32'h8000_0008 : 32'h8000_2004,
          first_lsu ? 32'h0000_0113 : 32'h1111_2222, 1'b0);

    // Memory backpressure: mem_reqReady low for 5 ISSUE cycles.
    tick();
    lsu_reqValid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_wmask = 4'b1100;
    #1;
    check("bp_ready", lsu_reqReady, 1);
    tick();
    lsu_reqValid = 1'b0; lsu_addr = 32'h0; lsu_wmask = 4'h0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", mem_reqValid, 1);
      check("bp_hold_addr", mem_addr, 32'h8000_3000);
      check("bp_hold_wmask", mem_wmask, 4'b1100);
      tick();
    end
    mem_reqReady = 1'b1;
    #1;
    check("bp_accept_valid", mem_reqValid, 1);
    tick();
    mem_reqReady = 1'b0; mem_respValid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #1;
    check("bp_no_early_resp", lsu_respValid, 0);
    tick();
    mem_respValid = 1'b0;
    #1;
    check("bp_resp_valid", lsu_respValid, 1);
    check("bp_resp_data", lsu_rdata, 32'h0BAD_F00D);
    check("bp_no_err", bus_err, 0);

    // Timeout: memory accepts but never responds.
    tick();
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_4000;
    #1;
    check("to_ready", ifu_reqReady, 1);
    tick();
    ifu_reqValid = 1'b0; mem_reqReady = 1'b1;
    #1;
    for (int i = 1; i < 8; i++) begin
      tick();
      mem_reqReady = 1'b0;
      #1;
      check("to_wait_no_resp", ifu_respValid, 0);
      check("to_wait_no_err", bus_err, 0);
    end
    tick();
    #1;
    check("to_resp_valid", ifu_respValid, 1);
    check("to_resp_zero", ifu_rdata, 0);
    check("to_err_set", bus_err, 1);
    tick();
    #1;
    check("to_pulse_end", ifu_respValid, 0);
    check("to_err_sticky", bus_err, 1);

    // Reset while in WAIT: everything clears at once, no response pulse.
    lsu_reqValid = 1'b1; lsu_addr = 32'h8000_5000; lsu_wen = 1'b0; lsu_wmask = 4'hF;
    #1;
    check("rw_ready", lsu_reqReady, 1);
    tick();
    lsu_reqValid = 1'b0; mem_reqReady = 1'b1;
    tick();
    mem_reqReady = 1'b0;
    #1;
    rst = 1'b1; mem_respValid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("rw_mem_valid", mem_reqValid, 0);
    check("rw_mem_addr", mem_addr, 0);
    check("rw_mem_wmask", mem_wmask, 0);
    check("rw_bus_err", bus_err, 0);
    check("rw_lsu_rdata", lsu_rdata, 0);
    check("rw_resp", {ifu_respValid, lsu_respValid}, 0);
    tick();
    check("rw_resp_in_rst", lsu_respValid, 0);
    rst = 1'b0; mem_respValid = 1'b0;
    tick();
    check("rw_resp_after_rst", lsu_respValid, 0);
    check("rw_idle_mem_valid", mem_reqValid, 0);

    // Normal request after the aborted transaction.
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0010;
    #1;
    check("post_rst_ready", ifu_reqReady, 1);
    serve(1'b0, 32'h8000_0010, 32'h0000_0093, 1'b0);
    check("post_rst_err", bus_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
